// File: rtl/bb_uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encodings and frame timing.
package bb_uart_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned FRAME_CYC = 10;  // txbsy high time of one frame: start, 8 data, stop
  localparam int unsigned TO_W      = 4;   // timeout counter width, covers TO up to 15

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BSY  = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/bb_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module bb_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [PW-1:0]   idx
);

  logic [PW-1:0] pos;

  // Scan from the farthest offset down to ptr itself so the nearest request is written last.
  always_comb begin
    win = '0;
    idx = '0;
    pos = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = PW'((32'(ptr) + NREQ - 1 - k) % NREQ);
      if (req[pos]) begin
        win      = '0;
        win[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/bb_uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte sources.
module bb_uart_tx_arb
  import bb_uart_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned TO   = 3,
  parameter int unsigned CW   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*BYTE_W-1:0] data,
  output logic [NREQ-1:0]        ack,
  output logic [NREQ-1:0]        gnt,
  output logic                   txen,
  output logic [BYTE_W-1:0]      txreg,
  input  logic                   txbsy,
  output logic                   busy,
  output logic                   err,
  output logic [CW-1:0]          frames
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e      state;
  logic [PW-1:0]   ptr;
  logic [TO_W-1:0] to_cnt;
  logic [NREQ-1:0] win;
  logic [PW-1:0]   win_idx;

  bb_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req (req),
    .ptr (ptr),
    .win (win),
    .idx (win_idx)
  );

  // Frame sequencer: grant, pulse txen, wait for txbsy rise, then for its fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= '0;
      to_cnt <= '0;
      ack    <= '0;
      gnt    <= '0;
      txen   <= 1'b0;
      txreg  <= '0;
      busy   <= 1'b0;
      err    <= 1'b0;
      frames <= '0;
    end else begin
      ack  <= '0;
      txen <= 1'b0;
      case (state)
        IDLE: begin
          if (en && (|req) && !txbsy) begin
            gnt   <= win;
            txreg <= data[32'(win_idx)*BYTE_W +: BYTE_W];
            txen  <= 1'b1;
            ptr   <= (32'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
            busy  <= 1'b1;
            state <= START;
          end
        end
        START: begin
          to_cnt <= '0;
          state  <= WAIT_BSY;
        end
        WAIT_BSY: begin
          if (txbsy) begin
            state <= WAIT_DONE;
          end else if (to_cnt == TO_W'(TO - 1)) begin
            // TX never started: drop the grant without ack; the requester retries later.
            err   <= 1'b1;
            gnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!txbsy) begin
            ack    <= gnt;
            gnt    <= '0;
            frames <= frames + 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
